// File: rtl/alu_sequencer_if.sv
// Board-side bundle of the ALU operand-entry sequencer: switches, ALU result in,
// registered operands, opcode, display value and step indicators out.
interface alu_sequencer_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] data_in;
    logic [N-1:0] alu_result;
    logic         alu_carry;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [1:0]   opcode;
    logic [15:0]  display_value;
    logic [1:0]   state;
    logic         result_valid;

    modport master (
        input  data_in, alu_result, alu_carry,
        output A, B, opcode, display_value, state, result_valid
    );

    modport slave (
        output data_in, alu_result, alu_carry,
        input  A, B, opcode, display_value, state, result_valid
    );
endinterface

// File: rtl/alu_sequencer.sv
// Centre-button driven entry sequence (A, B, opcode, result) for the lab ALU.
// Optional button debounce is compiled in with DEBOUNCE_ALU_SEQ_EN.
module alu_sequencer #(
    parameter int unsigned N               = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            BTNC,
    alu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        ENTER_OP,
        CALC,
        SHOW_RES
    } state_e;

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("alu_sequencer: DEBOUNCE_CYCLES must be at least 1");
    end
    if (N + 1 > 16) begin : g_bad_width
        $error("alu_sequencer: {carry, result} must fit the 16-bit display");
    end

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic [N:0]   res_q, res_d;
    logic         btn_meta_q, btn_s;
    logic         press;
    logic [15:0]  display_c;
    logic [1:0]   step_c;
    logic         valid_c;

    // Two-flop synchronizer for the raw, asynchronous button
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_s      <= 1'b0;
        end else begin
            btn_meta_q <= BTNC;
            btn_s      <= btn_meta_q;
        end
    end

`ifdef DEBOUNCE_ALU_SEQ_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt_q;
    logic             btn_acc_q, btn_acc_prev_q;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt_q       <= '0;
            btn_acc_q      <= 1'b0;
            btn_acc_prev_q <= 1'b0;
        end else begin
            btn_acc_prev_q <= btn_acc_q;
            if (btn_s == btn_acc_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q  <= '0;
                btn_acc_q <= btn_s;
            end else begin
                db_cnt_q <= db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign press = btn_acc_q & ~btn_acc_prev_q;
`else
    logic btn_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) btn_prev_q <= 1'b0;
        else       btn_prev_q <= btn_s;
    end

    assign press = btn_s & ~btn_prev_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Step sequencing; CALC is a single unconditional cycle so presses there are dropped
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            ENTER_A: begin
                if (press) begin
                    a_d     = bus.data_in;
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                if (press) begin
                    b_d     = bus.data_in;
                    state_d = ENTER_OP;
                end
            end
            ENTER_OP: begin
                if (press) begin
                    op_d    = bus.data_in[1:0];
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d   = {bus.alu_carry, bus.alu_result};
                state_d = SHOW_RES;
            end
            SHOW_RES: begin
                if (press) state_d = ENTER_A;
            end
            default: state_d = ENTER_A;
        endcase
    end

    // Display shows a live preview of the switches while entering values
    always_comb begin
        display_c = 16'(bus.data_in);
        step_c    = 2'b00;
        valid_c   = 1'b0;
        case (state_q)
            ENTER_A: step_c = 2'b00;
            ENTER_B: step_c = 2'b01;
            ENTER_OP: begin
                display_c = 16'(bus.data_in[1:0]);
                step_c    = 2'b10;
            end
            CALC: begin
                display_c = 16'(res_q);
                step_c    = 2'b11;
            end
            SHOW_RES: begin
                display_c = 16'(res_q);
                step_c    = 2'b11;
                valid_c   = 1'b1;
            end
            default: step_c = 2'b00;
        endcase
    end

    assign bus.A             = a_q;
    assign bus.B             = b_q;
    assign bus.opcode        = op_q;
    assign bus.display_value = display_c;
    assign bus.state         = step_c;
    assign bus.result_valid  = valid_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; define DEBOUNCE_ALU_SEQ_EN to also cover
// the debounce path with DEBOUNCE_CYCLES = 4.
module tb_alu_sequencer;

    localparam int unsigned DB = 4;
`ifdef DEBOUNCE_ALU_SEQ_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic BTNC  = 1'b0;
    logic [8:0] alu9;
    int checks = 0;
    int errors = 0;

    alu_sequencer_if #(.N(8)) bus ();

    alu_sequencer #(.N(8), .DEBOUNCE_CYCLES(DB)) dut (
        .clock (clock),
        .reset (reset),
        .BTNC  (BTNC),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Reference ALU: 0 add, 1 subtract (borrow in bit 8), 2 and, 3 or
    always_comb begin
        case (bus.opcode)
            2'd0:    alu9 = {1'b0, bus.A} + {1'b0, bus.B};
            2'd1:    alu9 = {1'b0, bus.A} - {1'b0, bus.B};
            2'd2:    alu9 = {1'b0, bus.A & bus.B};
            default: alu9 = {1'b0, bus.A | bus.B};
        endcase
    end
    assign bus.alu_result = alu9[7:0];
    assign bus.alu_carry  = alu9[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [7:0] d);
        bus.data_in = d;
        BTNC = 1'b1;
        tick(LAT + 1);
        BTNC = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_reset;
        bus.data_in = 8'h5A;
        #1 reset = 1'b1;
        #2;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state got %0h exp 0", bus.state); end
        checks++; if (bus.A !== 8'h00) begin errors++; $display("FAIL reset_A got %0h exp 0", bus.A); end
        checks++; if (bus.B !== 8'h00) begin errors++; $display("FAIL reset_B got %0h exp 0", bus.B); end
        checks++; if (bus.opcode !== 2'b00) begin errors++; $display("FAIL reset_opcode got %0h exp 0", bus.opcode); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", bus.result_valid); end
        checks++; if (bus.display_value !== 16'h005A) begin errors++; $display("FAIL reset_display got %0h exp 5a", bus.display_value); end
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_full_sequence;
        press(8'h2D);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL seq_state_b got %0h exp 1", bus.state); end
        checks++; if (bus.A !== 8'h2D) begin errors++; $display("FAIL seq_A got %0h exp 2d", bus.A); end
        bus.data_in = 8'h13;
        #1;
        checks++; if (bus.display_value !== 16'h0013) begin errors++; $display("FAIL seq_preview_b got %0h exp 13", bus.display_value); end
        press(8'h13);
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL seq_state_op got %0h exp 2", bus.state); end
        checks++; if (bus.B !== 8'h13) begin errors++; $display("FAIL seq_B got %0h exp 13", bus.B); end
        bus.data_in = 8'hFE;
        #1;
        checks++; if (bus.display_value !== 16'h0002) begin errors++; $display("FAIL seq_preview_op got %0h exp 2", bus.display_value); end
        bus.data_in = 8'hFC;
        BTNC = 1'b1;
        tick(LAT);
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL seq_op_early got %0h exp 2", bus.state); end
        tick(1);
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL seq_calc_state got %0h exp 3", bus.state); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL seq_calc_valid got %0h exp 0", bus.result_valid); end
        checks++; if (bus.display_value !== 16'h0000) begin errors++; $display("FAIL seq_calc_display got %0h exp 0", bus.display_value); end
        checks++; if (bus.opcode !== 2'b00) begin errors++; $display("FAIL seq_opcode got %0h exp 0", bus.opcode); end
        tick(1);
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL seq_show_valid got %0h exp 1", bus.result_valid); end
        checks++; if (bus.display_value !== 16'h0040) begin errors++; $display("FAIL seq_show_display got %0h exp 40", bus.display_value); end
        BTNC = 1'b0;
        tick(LAT + 2);
        checks++; if (bus.state !== 2'b11 || bus.result_valid !== 1'b1) begin errors++; $display("FAIL seq_show_hold got %0h/%0h exp 3/1", bus.state, bus.result_valid); end
    endtask

    task automatic test_carry;
        press(8'h77);
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL car_back_state got %0h exp 0", bus.state); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL car_back_valid got %0h exp 0", bus.result_valid); end
        checks++; if (bus.A !== 8'h2D) begin errors++; $display("FAIL car_keep_A got %0h exp 2d", bus.A); end
        checks++; if (bus.display_value !== 16'h0077) begin errors++; $display("FAIL car_preview_a got %0h exp 77", bus.display_value); end
        press(8'hFF);
        press(8'h01);
        bus.data_in = 8'h00;
        BTNC = 1'b1;
        tick(LAT + 1);
        checks++; if (bus.display_value !== 16'h0040) begin errors++; $display("FAIL car_calc_prev got %0h exp 40", bus.display_value); end
        tick(1);
        checks++; if (bus.display_value !== 16'h0100) begin errors++; $display("FAIL car_display got %0h exp 100", bus.display_value); end
        checks++; if (bus.A !== 8'hFF || bus.B !== 8'h01) begin errors++; $display("FAIL car_operands got %0h/%0h exp ff/1", bus.A, bus.B); end
        BTNC = 1'b0;
        tick(LAT + 2);
        press(8'h00);
        bus.data_in = 8'h09;
        #1;
        checks++; if (bus.state !== 2'b00 || bus.display_value !== 16'h0009) begin errors++; $display("FAIL car_return got %0h/%0h exp 0/9", bus.state, bus.display_value); end
    endtask

    task automatic test_held;
        bus.data_in = 8'h11;
        BTNC = 1'b1;
        tick(50);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL held_state got %0h exp 1", bus.state); end
        checks++; if (bus.A !== 8'h11) begin errors++; $display("FAIL held_A got %0h exp 11", bus.A); end
        BTNC = 1'b0;
        tick(LAT + 4);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL held_release got %0h exp 1", bus.state); end
    endtask

    task automatic test_reset_mid;
        press(8'h22);
        bus.data_in = 8'h05;
        BTNC = 1'b1;
        tick(LAT + 1);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rcalc_state got %0h exp 0", bus.state); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL rcalc_valid got %0h exp 0", bus.result_valid); end
        checks++; if (bus.A !== 8'h00 || bus.B !== 8'h00 || bus.opcode !== 2'b00) begin errors++; $display("FAIL rcalc_regs got %0h/%0h/%0h exp 0/0/0", bus.A, bus.B, bus.opcode); end
        checks++; if (bus.display_value !== 16'h0005) begin errors++; $display("FAIL rcalc_display got %0h exp 5", bus.display_value); end
        bus.data_in = 8'h3C;
        tick(2);
        reset = 1'b0;
        tick(LAT + 1);
        checks++; if (bus.state !== 2'b01 || bus.A !== 8'h3C) begin errors++; $display("FAIL rheld_press got %0h/%0h exp 1/3c", bus.state, bus.A); end
        BTNC = 1'b0;
        tick(LAT + 2);
        press(8'h3D);
        bus.data_in = 8'h01;
        BTNC = 1'b1;
        tick(LAT + 1);
        checks++; if (bus.display_value !== 16'h0000) begin errors++; $display("FAIL rcalc_res_cleared got %0h exp 0", bus.display_value); end
        tick(1);
        checks++; if (bus.display_value !== 16'h01FF) begin errors++; $display("FAIL rsub_borrow got %0h exp 1ff", bus.display_value); end
        BTNC = 1'b0;
        tick(LAT + 2);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.state !== 2'b00 || bus.result_valid !== 1'b0) begin errors++; $display("FAIL rshow got %0h/%0h exp 0/0", bus.state, bus.result_valid); end
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

`ifdef DEBOUNCE_ALU_SEQ_EN
    task automatic test_debounce;
        bus.data_in = 8'h44;
        BTNC = 1'b1;
        tick(3);
        BTNC = 1'b0;
        tick(10);
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL db_glitch got %0h exp 0", bus.state); end
        BTNC = 1'b1;
        tick(6);
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL db_early got %0h exp 0", bus.state); end
        tick(1);
        checks++; if (bus.state !== 2'b01 || bus.A !== 8'h44) begin errors++; $display("FAIL db_press got %0h/%0h exp 1/44", bus.state, bus.A); end
        tick(3);
        BTNC = 1'b0;
        tick(10);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL db_release got %0h exp 1", bus.state); end
    endtask
`endif

    initial begin
        bus.data_in = 8'h00;
        test_reset;
        test_full_sequence;
        test_carry;
        test_held;
        test_reset_mid;
`ifdef DEBOUNCE_ALU_SEQ_EN
        test_debounce;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
